// File: rtl/m68k_bus_master.sv
// m68k_bus_master: turns a request/acknowledge host port into 68000-style
// asynchronous bus cycles (AS/UDS/LDS/R_W, DTACK) paced by the 7 MHz enable.
// Includes a DTACK timeout, abort on chipset reset and debounced IPL decoding.
module m68k_bus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk7_en,
    input  logic        req,
    input  logic        we,
    input  logic [22:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  be,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] cpu_address,
    output logic [15:0] cpudata_in,
    input  logic [15:0] cpu_data,
    output logic        ami_cpu_as,
    output logic        ami_cpu_uds,
    output logic        ami_cpu_lds,
    output logic        cpu_r_w,
    input  logic        ami_cpu_dtack,
    input  logic        ami_cpu_reset,
    input  logic [2:0]  ami_cpu_ipl,
    output logic [2:0]  ipl_level
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_WAIT,
        S_END
    } state_t;

    state_t            state, state_next;

    logic              dtack_p0, dtack_p1;
    logic [2:0]        ipl_p0, ipl_p1, ipl_prev;

    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              we_lat, we_lat_next;
    logic [1:0]        be_lat, be_lat_next;
    logic              busy_next, ack_next, err_next;
    logic [15:0]       rdata_next;
    logic [22:0]       cpu_address_next;
    logic [15:0]       cpudata_in_next;
    logic              as_next, uds_next, lds_next, r_w_next;

    // Two-flop synchronisers for the asynchronous DTACK and IPL inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dtack_p0 <= 1'b1;
            dtack_p1 <= 1'b1;
            ipl_p0   <= 3'b111;
            ipl_p1   <= 3'b111;
        end else begin
            dtack_p0 <= ami_cpu_dtack;
            dtack_p1 <= dtack_p0;
            ipl_p0   <= ami_cpu_ipl;
            ipl_p1   <= ipl_p0;
        end
    end

    // IPL debounce: level updates only when two consecutive ticks agree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ipl_prev  <= 3'b111;
            ipl_level <= 3'd0;
        end else if (clk7_en) begin
            ipl_prev <= ipl_p1;
            if (ipl_p1 == ipl_prev) begin
                ipl_level <= ~ipl_p1;
            end
        end
    end

    // Bus state and all registered bus/host outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            we_lat      <= 1'b0;
            be_lat      <= 2'b11;
            busy        <= 1'b0;
            ack         <= 1'b0;
            err         <= 1'b0;
            rdata       <= 16'h0000;
            cpu_address <= 23'd0;
            cpudata_in  <= 16'h0000;
            ami_cpu_as  <= 1'b1;
            ami_cpu_uds <= 1'b1;
            ami_cpu_lds <= 1'b1;
            cpu_r_w     <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            we_lat      <= we_lat_next;
            be_lat      <= be_lat_next;
            busy        <= busy_next;
            ack         <= ack_next;
            err         <= err_next;
            rdata       <= rdata_next;
            cpu_address <= cpu_address_next;
            cpudata_in  <= cpudata_in_next;
            ami_cpu_as  <= as_next;
            ami_cpu_uds <= uds_next;
            ami_cpu_lds <= lds_next;
            cpu_r_w     <= r_w_next;
        end
    end

    // Next-state and output decode; chipset-reset abort overrides everything
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        we_lat_next      = we_lat;
        be_lat_next      = be_lat;
        busy_next        = busy;
        ack_next         = 1'b0;
        err_next         = err;
        rdata_next       = rdata;
        cpu_address_next = cpu_address;
        cpudata_in_next  = cpudata_in;
        as_next          = ami_cpu_as;
        uds_next         = ami_cpu_uds;
        lds_next         = ami_cpu_lds;
        r_w_next         = cpu_r_w;

        case (state)
            S_IDLE: begin
                if (clk7_en && req && ami_cpu_reset) begin
                    we_lat_next      = we;
                    be_lat_next      = (be == 2'b00) ? 2'b11 : be;
                    cpu_address_next = addr;
                    cpudata_in_next  = wdata;
                    r_w_next         = ~we;
                    busy_next        = 1'b1;
                    state_next       = S_ADDR;
                end
            end
            S_ADDR: begin
                if (clk7_en) begin
                    as_next = 1'b0;
                    if (!we_lat) begin
                        uds_next = ~be_lat[1];
                        lds_next = ~be_lat[0];
                    end
                    state_next = S_STROBE;
                end
            end
            S_STROBE: begin
                if (clk7_en) begin
                    if (we_lat) begin
                        uds_next = ~be_lat[1];
                        lds_next = ~be_lat[0];
                    end
                    cnt_next   = '0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (clk7_en) begin
                    if (!dtack_p1) begin
                        if (!we_lat) begin
                            rdata_next = cpu_data;
                        end
                        ack_next   = 1'b1;
                        err_next   = 1'b0;
                        as_next    = 1'b1;
                        uds_next   = 1'b1;
                        lds_next   = 1'b1;
                        state_next = S_END;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        rdata_next = 16'hFFFF;
                        ack_next   = 1'b1;
                        err_next   = 1'b1;
                        as_next    = 1'b1;
                        uds_next   = 1'b1;
                        lds_next   = 1'b1;
                        state_next = S_END;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            S_END: begin
                if (clk7_en) begin
                    r_w_next   = 1'b1;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if ((state != S_IDLE) && !ami_cpu_reset) begin
            as_next    = 1'b1;
            uds_next   = 1'b1;
            lds_next   = 1'b1;
            r_w_next   = 1'b1;
            ack_next   = 1'b1;
            err_next   = 1'b1;
            rdata_next = 16'hFFFF;
            busy_next  = 1'b0;
            state_next = S_IDLE;
        end
    end

endmodule

// File: doc/m68k_bus_master.md
Name: m68k_bus_master

Overview:
- Initiator side of the Minimig 68000 CPU bus.
- Converts a simple request/acknowledge host interface into 68000-style asynchronous bus cycles (active-low AS/UDS/LDS, R/W, DTACK) paced by the 7 MHz clock enable.
- Provides a DTACK timeout and aborts cycles on Minimig reset.
- Synchronises and debounces the interrupt priority lines.
- Used by test harnesses and any soft bus master that talks to the Minimig chipset in place of the CPU core.

Parameters:
- TIMEOUT, 255: clk7_en ticks to wait for DTACK before forcing a bus-error completion; 0 disables the timeout.

Ports:
- clk  in  1  28.37516 MHz system clock
- rst  in  1  asynchronous active-high reset
- clk7_en  in  1  7 MHz clock enable; all bus state advances only on clk7_en=1
- req  in  1  host request; sampled in IDLE only
- we  in  1  1=write, 0=read
- addr  in  23  word address [23:1]
- wdata  in  16  write data
- be  in  2  byte enables {upper,lower}
- busy  out  1  cycle in progress
- ack  out  1  one-clk completion pulse
- err  out  1  valid with ack; 1=timeout or abort
- rdata  out  16  read data, valid from ack until next ack
- cpu_address  out  23  bus address
- cpudata_in  out  16  data driven toward the chipset
- cpu_data  in  16  data returned by the chipset
- ami_cpu_as  out  1  address strobe, active low
- ami_cpu_uds  out  1  upper data strobe, active low
- ami_cpu_lds  out  1  lower data strobe, active low
- cpu_r_w  out  1  1=read, 0=write
- ami_cpu_dtack  in  1  data acknowledge, active low, asynchronous
- ami_cpu_reset  in  1  chipset reset, active low
- ami_cpu_ipl  in  3  interrupt priority, active low, asynchronous
- ipl_level  out  3  decoded, stable interrupt level (0–7)

Behaviour:
- Reset values:
  - ami_cpu_as, ami_cpu_uds, ami_cpu_lds = 1; cpu_r_w = 1.
  - cpu_address = 0; cpudata_in = 0; rdata = 16'h0000.
  - busy, ack, err = 0; ipl_level = 0; state = IDLE; timeout counter = 0.
- ami_cpu_dtack and ami_cpu_ipl pass through 2-flop synchronisers before use.
- be = 2'b00 is treated as 2'b11.
- States; each transition happens on a clk edge with clk7_en=1 unless stated otherwise:
  - IDLE: on req=1, latch addr/wdata/we/be. Drive cpu_address, cpu_r_w=~we, cpudata_in=wdata. busy=1. Go to ADDR (tick T0).
  - ADDR: ami_cpu_as=0. On reads, assert the selected UDS/LDS. Go to STROBE (T1).
  - STROBE: on writes, assert the selected UDS/LDS. Clear the counter. Go to WAIT (T2).
  - WAIT: on each tick:
    - If the synchronised dtack is 0: rdata <= cpu_data (reads only; writes leave rdata unchanged), ack=1, err=0, deassert AS/UDS/LDS, go to END.
    - Else if TIMEOUT≠0 and counter == TIMEOUT−1: rdata = 16'hFFFF, ack=1, err=1, deassert strobes, go to END.
    - Else increment the counter.
  - END: hold cpu_address and cpu_r_w. Then cpu_r_w=1, busy=0, go to IDLE.
- Zero-wait latency: req sampled at tick T0, dtack sampled low at T3, ack in the clk following T3. Earliest next acceptance is tick T5.
- ack is high for exactly one clk; req must drop or a new request will be accepted in IDLE.
- req and changes to its fields while busy=1 are ignored.
- Abort: ami_cpu_reset=0 in any non-IDLE state takes effect on the next clk regardless of clk7_en.
  - Strobes deassert, cpu_r_w=1, ack=1, err=1, rdata=16'hFFFF, state goes directly to IDLE.
  - In IDLE, req is not accepted while ami_cpu_reset=0.
- Simultaneous abort and dtack on the same clk: abort wins.
- IPL: the synchronised value must be identical on two consecutive clk7_en ticks. Only then ipl_level <= ~ami_cpu_ipl_sync. Otherwise ipl_level holds.
- rst asserted mid-cycle: immediate return to reset values, no ack.

Test Plan:
- Read at 0x00DFF004 (word addr 23'h6FF802), be=11, dtack tied low, cpu_data=16'h1234 -> AS low from T1 to T3; ack one clk after T3 with rdata=16'h1234, err=0; busy=0 after T4.
- Write of 16'hA55A to addr 23'h000100 with be=10, dtack low 3 ticks late -> UDS low and LDS high from T2; cpu_r_w=0 from T0; ack at T6; cpudata_in=16'hA55A throughout.
- Read with dtack held high, TIMEOUT=4 -> ack with err=1 and rdata=16'hFFFF exactly 4 ticks after entering WAIT; strobes high afterwards.
- ami_cpu_reset pulsed low during WAIT -> strobes high and ack+err on the very next clk; a req held during reset is accepted only after ami_cpu_reset returns high.
- ami_cpu_ipl toggles 3'b010 -> 3'b101 for one tick then settles at 3'b011 -> ipl_level stays 5 through the glitch, becomes 4 after two stable ticks.
- Back-to-back reads with req held high -> second AS falling edge occurs no earlier than T6 of the first cycle; each cycle produces exactly one ack.
